// File: rtl/ldpc_enc_ctrl_if.sv
// Signal bundle between the LDPC encoder sequencer and its surroundings
// (matrix loader, info source, codeword sink and the encode datapath).
interface ldpc_enc_ctrl_if #(
  parameter int N = 11,
  parameter int K = 6
);
  logic                 cfg_clear;
  logic                 cfg_row_valid;
  logic                 cfg_row_ready;
  logic [N-K-1:0]       cfg_row;
  logic                 cfg_done;
  logic                 in_valid;
  logic                 in_ready;
  logic [K-1:0]         in_bits;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         out_code;
  logic [K-1:0]         enc_info;
  logic [K*(N-K)-1:0]   enc_gen_p;
  logic                 enc_en;
  logic [N-1:0]         enc_code;
  logic                 busy;
  logic [15:0]          cw_count;

  // Controller side
  modport slave (
    input  cfg_clear, cfg_row_valid, cfg_row, in_valid, in_bits, out_ready, enc_code,
    output cfg_row_ready, cfg_done, in_ready, out_valid, out_code,
           enc_info, enc_gen_p, enc_en, busy, cw_count
  );

  // Environment side (loader, source, sink, encoder)
  modport master (
    output cfg_clear, cfg_row_valid, cfg_row, in_valid, in_bits, out_ready, enc_code,
    input  cfg_row_ready, cfg_done, in_ready, out_valid, out_code,
           enc_info, enc_gen_p, enc_en, busy, cw_count
  );
endinterface

// File: rtl/ldpc_enc_ctrl.sv
// Sequencer for a systematic LDPC encoder: loads parity rows, runs one info word at a time.
// Define LDPC_ENC_CTRL_CNT_EN to build the delivered-codeword counter on cw_count.
module ldpc_enc_ctrl #(
  parameter int N       = 11,
  parameter int K       = 6,
  parameter int ENC_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  ldpc_enc_ctrl_if.slave bus
);
  localparam int R   = N - K;
  localparam int GW  = K * R;
  localparam int RCW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {CFG, IDLE, RUN, HOLD} state_t;

  state_t         state_q, state_d;
  logic [RCW-1:0] row_cnt_q, row_cnt_d;
  logic [3:0]     lat_cnt_q, lat_cnt_d;
  logic [GW-1:0]  gen_p_q, gen_p_d;
  logic [K-1:0]   info_q, info_d;
  logic [N-1:0]   code_q, code_d;
  logic           en_q, en_d;

  logic row_hs, in_hs, out_hs, clr_hs;

  assign row_hs = (state_q == CFG) & bus.cfg_row_valid;
  assign clr_hs = (state_q == IDLE) & bus.cfg_clear;
  assign in_hs  = (state_q == IDLE) & ~bus.cfg_clear & bus.in_valid;
  assign out_hs = (state_q == HOLD) & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    lat_cnt_d = lat_cnt_q;
    gen_p_d   = gen_p_q;
    info_d    = info_q;
    code_d    = code_q;
    en_d      = 1'b0;
    unique case (state_q)
      CFG: begin
        // Rows shift in from the LSB end so row 0 ends up in the MSBs.
        if (row_hs) begin
          gen_p_d = {gen_p_q[GW-R-1:0], bus.cfg_row};
          if (row_cnt_q == RCW'(K - 1)) begin
            row_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            row_cnt_d = row_cnt_q + RCW'(1);
          end
        end
      end
      IDLE: begin
        if (clr_hs) begin
          gen_p_d = '0;
          state_d = CFG;
        end else if (in_hs) begin
          info_d    = bus.in_bits;
          lat_cnt_d = 4'(ENC_LAT);
          en_d      = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (lat_cnt_q == 4'd0) begin
          code_d  = bus.enc_code;
          state_d = HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (out_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = CFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CFG;
      row_cnt_q <= '0;
      lat_cnt_q <= '0;
      gen_p_q   <= '0;
      info_q    <= '0;
      code_q    <= '0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      gen_p_q   <= gen_p_d;
      info_q    <= info_d;
      code_q    <= code_d;
      en_q      <= en_d;
    end
  end

  assign bus.cfg_row_ready = (state_q == CFG);
  assign bus.cfg_done      = (state_q != CFG);
  assign bus.in_ready      = (state_q == IDLE) & ~bus.cfg_clear;
  assign bus.out_valid     = (state_q == HOLD);
  assign bus.busy          = (state_q == RUN) | (state_q == HOLD);
  assign bus.out_code      = code_q;
  assign bus.enc_info      = info_q;
  assign bus.enc_gen_p     = gen_p_q;
  assign bus.enc_en        = en_q;

`ifdef LDPC_ENC_CTRL_CNT_EN
  logic [15:0] cw_count_q, cw_count_d;

  // An honoured clear restarts the count along with the matrix.
  always_comb begin
    cw_count_d = cw_count_q;
    if (clr_hs) begin
      cw_count_d = '0;
    end else if (out_hs) begin
      cw_count_d = cw_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_count_q <= '0;
    end else begin
      cw_count_q <= cw_count_d;
    end
  end

  assign bus.cw_count = cw_count_q;
`else
  assign bus.cw_count = 16'h0;
`endif

endmodule

// File: tb/tb_ldpc_enc_ctrl.sv
// Self-checking bench for ldpc_enc_ctrl: reference encoder, transaction-level model,
// per-cycle comparison plus directed literal checks.
module tb_ldpc_enc_ctrl;
  localparam int N       = 11;
  localparam int K       = 6;
  localparam int ENC_LAT = 1;
  localparam int R       = N - K;
  localparam int GW      = K * R;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  ldpc_enc_ctrl_if #(.N(N), .K(K)) bus ();

  ldpc_enc_ctrl #(.N(N), .K(K), .ENC_LAT(ENC_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // codeword = {info, info * P mod 2}; info MSB pairs with row 0 (packed MSBs)
  function automatic logic [N-1:0] ref_encode(input logic [K-1:0] info, input logic [GW-1:0] gp);
    logic [R-1:0] par;
    par = '0;
    for (int i = 0; i < K; i++)
      if (info[K-1-i]) par = par ^ gp[GW-1-i*R -: R];
    return {info, par};
  endfunction

  // Encoder stand-in: result appears ENC_LAT edges after the enable cycle
  logic [N-1:0] enc_pipe [ENC_LAT];
  always @(posedge clk) begin
    for (int s = ENC_LAT - 1; s > 0; s--) enc_pipe[s] <= enc_pipe[s-1];
    if (bus.enc_en) enc_pipe[0] <= ref_encode(bus.enc_info, bus.enc_gen_p);
  end
  assign bus.enc_code = enc_pipe[ENC_LAT-1];

  // Transaction-level model
  logic [R-1:0] m_p [K];
  int           m_rows  = 0;
  bit           m_pend  = 0;
  bit           m_hold  = 0;
  bit           m_en    = 0;
  int           m_wait  = 0;
  logic [K-1:0] m_info  = '0;
  logic [N-1:0] m_code  = '0;
  logic [15:0]  m_count = '0;
  logic [15:0]  cnt_base = '0;

  function automatic logic [GW-1:0] model_gen();
    logic [GW-1:0] g;
    g = '0;
    for (int i = 0; i < K; i++)
      if (i < m_rows) g = (g << R) | GW'(m_p[i]);
    return g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rows <= 0; m_pend <= 0; m_hold <= 0; m_en <= 0; m_wait <= 0;
      m_info <= '0; m_code <= '0; m_count <= '0;
      for (int i = 0; i < K; i++) m_p[i] <= '0;
    end else begin
      m_en <= 0;
      if (m_rows < K) begin
        if (bus.cfg_row_valid) begin
          m_p[m_rows] <= bus.cfg_row;
          m_rows      <= m_rows + 1;
        end
      end else if (!m_pend && !m_hold) begin
        if (bus.cfg_clear) begin
          m_rows  <= 0;
          m_count <= '0;
          for (int i = 0; i < K; i++) m_p[i] <= '0;
        end else if (bus.in_valid) begin
          m_info <= bus.in_bits;
          m_pend <= 1;
          m_wait <= ENC_LAT + 1;
          m_en   <= 1;
        end
      end else if (m_pend) begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) begin
          m_pend <= 0;
          m_hold <= 1;
          m_code <= ref_encode(m_info, model_gen());
        end
      end else if (bus.out_ready) begin
        m_hold <= 0;
`ifdef LDPC_ENC_CTRL_CNT_EN
        m_count <= m_count + 16'd1;
`endif
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cfg_row_ready", bus.cfg_row_ready, (m_rows < K));
      checkOutput("cfg_done", bus.cfg_done, (m_rows == K));
      checkOutput("in_ready", bus.in_ready, (m_rows == K) && !m_pend && !m_hold && !bus.cfg_clear);
      checkOutput("out_valid", bus.out_valid, m_hold);
      checkOutput("busy", bus.busy, m_pend || m_hold);
      checkOutput("enc_en", bus.enc_en, m_en);
      checkOutput("enc_info", bus.enc_info, m_info);
      checkOutput("enc_gen_p", bus.enc_gen_p, model_gen());
      checkOutput("out_code", bus.out_code, m_code);
      checkOutput("cw_count", bus.cw_count, m_count + cnt_base);
    end
  end

  task automatic applyStimulus(input logic clr, input logic rv, input logic [R-1:0] row,
                               input logic iv, input logic [K-1:0] ib, input logic ordy);
    bus.cfg_clear     = clr;
    bus.cfg_row_valid = rv;
    bus.cfg_row       = row;
    bus.in_valid      = iv;
    bus.in_bits       = ib;
    bus.out_ready     = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_matrix(input logic [GW-1:0] gp);
    for (int i = 0; i < K; i++) begin
      applyStimulus(0, 1, gp[GW-1-i*R -: R], 0, '0, 0);
      step();
      if (i == K - 2) checkOutput("cfg_done_before_last_row", bus.cfg_done, 0);
    end
    applyStimulus(0, 0, '0, 0, '0, 0);
  endtask

  task automatic send_and_wait(input logic [K-1:0] info, input logic [N-1:0] exp_code, input string tag);
    int lat;
    int en_seen;
    applyStimulus(0, 0, '0, 1, info, 0);
    step();
    applyStimulus(0, 0, '0, 0, '0, 0);
    lat = 0;
    en_seen = int'(bus.enc_en);
    do begin
      step();
      lat++;
      en_seen += int'(bus.enc_en);
    end while (!bus.out_valid && lat < 20);
    checkOutput({tag, "_latency"}, lat, ENC_LAT + 1);
    checkOutput({tag, "_en_pulses"}, en_seen, 1);
    checkOutput({tag, "_code"}, bus.out_code, exp_code);
  endtask

  task automatic release_word(input string tag);
    applyStimulus(0, 0, '0, 0, '0, 1);
    step();
    applyStimulus(0, 0, '0, 0, '0, 0);
    checkOutput({tag, "_released"}, bus.out_valid, 0);
    checkOutput({tag, "_in_ready_after"}, bus.in_ready, 1);
  endtask

  task automatic deliver(input logic [K-1:0] info, input logic [N-1:0] exp_code,
                         input int hold_cycles, input string tag);
    send_and_wait(info, exp_code, tag);
    for (int c = 0; c < hold_cycles; c++) begin
      step();
      checkOutput({tag, "_bp_code"}, bus.out_code, exp_code);
      checkOutput({tag, "_bp_in_ready"}, bus.in_ready, 0);
      checkOutput({tag, "_bp_valid"}, bus.out_valid, 1);
    end
    release_word(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0, 0, '0, 0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_gen_p", bus.enc_gen_p, 0);
    checkOutput("rst_cfg_done", bus.cfg_done, 0);
    checkOutput("rst_cfg_row_ready", bus.cfg_row_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_cw_count", bus.cw_count, 0);
    rst_n = 1'b1;
    step();

    load_matrix({K{5'b11111}});
    checkOutput("cfg_done_loaded", bus.cfg_done, 1);
    checkOutput("gen_p_all_ones", bus.enc_gen_p, 30'h3FFFFFFF);
    checkOutput("in_ready_loaded", bus.in_ready, 1);

    deliver(6'b111111, 11'b11111100000, 0, "single");
    deliver(6'b100000, 11'b10000011111, 5, "backpressure");
    deliver(6'b110000, 11'b11000000000, 0, "even_parity");

    // cfg_clear while a codeword is held must be ignored
    send_and_wait(6'b000001, 11'b00000111111, "hold_clear");
    applyStimulus(1, 0, '0, 0, '0, 0);
    step();
    checkOutput("hold_clear_ignored_done", bus.cfg_done, 1);
    checkOutput("hold_clear_still_valid", bus.out_valid, 1);
    release_word("hold_clear");
    checkOutput("hold_clear_gen_kept", bus.enc_gen_p, 30'h3FFFFFFF);

    // Clear wins over a same-cycle info word
    applyStimulus(1, 0, '0, 1, 6'h3F, 0);
    #1;
    checkOutput("clear_blocks_in_ready", bus.in_ready, 0);
    step();
    applyStimulus(0, 0, '0, 1, 6'h3F, 0);
    checkOutput("clear_state_cfg", bus.cfg_row_ready, 1);
    checkOutput("clear_cfg_done", bus.cfg_done, 0);
    checkOutput("clear_gen_p", bus.enc_gen_p, 0);
    checkOutput("clear_cw_count", bus.cw_count, 0);
    checkOutput("clear_not_accepted", bus.busy, 0);
    step();
    checkOutput("cfg_rejects_info", bus.busy, 0);
    applyStimulus(0, 0, '0, 0, '0, 0);

    load_matrix({5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b11111});
    checkOutput("gen_p_reload", bus.enc_gen_p, 30'h0222221F);
    deliver(6'b101000, 11'b10100000101, 1, "reload_word");

    // Asynchronous reset in the middle of RUN
    applyStimulus(0, 0, '0, 1, 6'b010101, 0);
    step();
    applyStimulus(0, 0, '0, 0, '0, 0);
    checkOutput("pre_rst_busy", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_enc_en", bus.enc_en, 0);
    checkOutput("arst_busy", bus.busy, 0);
    checkOutput("arst_out_valid", bus.out_valid, 0);
    checkOutput("arst_gen_p", bus.enc_gen_p, 0);
    checkOutput("arst_info", bus.enc_info, 0);
    checkOutput("arst_out_code", bus.out_code, 0);
    checkOutput("arst_cfg_done", bus.cfg_done, 0);
    checkOutput("arst_state_cfg", bus.cfg_row_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("post_rst_no_valid", bus.out_valid, 0);
    end

    load_matrix({K{5'b11111}});
`ifdef LDPC_ENC_CTRL_CNT_EN
    force dut.cw_count_q = 16'hFFFE;
    cnt_base = 16'hFFFE - m_count;
    step();
    release dut.cw_count_q;
    checkOutput("cnt_preload", bus.cw_count, 16'hFFFE);
    deliver(6'b111111, 11'b11111100000, 0, "cnt1");
    checkOutput("cnt_ffff", bus.cw_count, 16'hFFFF);
    deliver(6'b100000, 11'b10000011111, 0, "cnt2");
    checkOutput("cnt_wrap", bus.cw_count, 16'h0000);
    deliver(6'b110000, 11'b11000000000, 0, "cnt3");
    checkOutput("cnt_after_wrap", bus.cw_count, 16'h0001);
`else
    deliver(6'b111111, 11'b11111100000, 0, "nocnt");
    checkOutput("cnt_tied_zero", bus.cw_count, 16'h0000);
`endif
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
